// File: rtl/instr_mem.sv
// -----------------------------------------------------------------------------
// instr_mem -- word-addressed instruction memory for the 32-bit MIPS pipeline.
//
// Holds 2**ADDR_W words of DATA_W bits. The read port is purely combinational
// (the IF stage owns the pipeline register). A synchronous write port loads
// programs. A synchronous active-low reset reloads the fixed boot image into
// every word. The same image is the power-up value, so the memory fetches
// valid code even if no reset has happened yet.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset, reloads the boot image
//   addr         read word index (a word index, not a byte address)
//   instruction  word at mem[addr], zero-cycle latency
//   we           write enable for program load
//   wr_addr      write word index
//   wr_data      word to write
// -----------------------------------------------------------------------------
module instr_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] instruction,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int DEPTH = 1 << ADDR_W;

    // Boot program: computes 5+3 and 5-3, stores/loads the sum, then spins
    // on a jump-to-self. Every word past the program is a nop.
    function automatic logic [DATA_W-1:0] boot_word(input int idx);
        logic [31:0] w;
        case (idx)
            0:       w = 32'h2001_0005; // addi $1,$0,5
            1:       w = 32'h2002_0003; // addi $2,$0,3
            2:       w = 32'h0022_1820; // add  $3,$1,$2
            3:       w = 32'h0022_2022; // sub  $4,$1,$2
            4:       w = 32'hAC03_0000; // sw   $3,0($0)
            5:       w = 32'h8C05_0000; // lw   $5,0($0)
            6:       w = 32'h0800_0006; // j    6 (halt loop)
            default: w = 32'h0000_0000; // nop
        endcase
        return DATA_W'(w);
    endfunction

    // Read-side view of every word, indexed by the read mux below.
    logic [DATA_W-1:0] word_q [DEPTH];

    // One register per word. A whole-array reset rules out block RAM anyway,
    // so each word is built as its own register with a private write decode.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            localparam logic [ADDR_W-1:0] IDX  = ADDR_W'(gi);
            localparam logic [DATA_W-1:0] BOOT = boot_word(gi);

            // Power-up value equals the boot image.
            logic [DATA_W-1:0] word_reg = BOOT;
            logic              wr_sel;

            assign wr_sel = we && (wr_addr == IDX);

            // Reset wins over a concurrent write: the write is dropped.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    word_reg <= BOOT;
                end else if (wr_sel) begin
                    word_reg <= wr_data;
                end
            end

            assign word_q[gi] = word_reg;
        end
    endgenerate

    // No bypass: a write to the word being read shows up only after the edge.
    assign instruction = word_q[addr];

endmodule

// File: tb/tb_instr_mem.sv
// -----------------------------------------------------------------------------
// tb_instr_mem -- self-checking bench for instr_mem.
// Directed checks for the boot image, combinational read, write, reset
// priority and back-to-back writes, followed by randomized traffic checked
// against a plain array model of the memory.
// -----------------------------------------------------------------------------
module tb_instr_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr;
    logic [31:0] instruction;
    logic        we;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: one entry per word.
    logic [31:0] model [256];

    instr_mem #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .instruction (instruction),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    always #100 clk = ~clk;

    task automatic load_boot();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        model[0] = 32'h20010005;
        model[1] = 32'h20020003;
        model[2] = 32'h00221820;
        model[3] = 32'h00222022;
        model[4] = 32'hAC030000;
        model[5] = 32'h8C050000;
        model[6] = 32'h08000006;
    endtask

    // One rising edge: the model applies the same rules as the memory.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) load_boot();
        else if (we) model[wr_addr] = wr_data;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] expected);
        #1;
        compared++;
        assert (instruction === expected)
        else begin
            mismatched++;
            $error("FAIL %s addr=%02h observed=%08h expected=%08h",
                   tag, addr, instruction, expected);
        end
        $display("check %-12s addr=%02h instruction=%08h expected=%08h",
                 tag, addr, instruction, expected);
    endtask

    logic [31:0] boot_tab [8];

    initial begin
        boot_tab = '{32'h20010005, 32'h20020003, 32'h00221820, 32'h00222022,
                     32'hAC030000, 32'h8C050000, 32'h08000006, 32'h00000000};
        load_boot();
        rst_n = 1'b1; we = 1'b0; wr_addr = 8'h00; wr_data = 32'h0; addr = 8'h00;

        // Power-up contents before any reset edge.
        check("powerup0", 32'h20010005);
        addr = 8'h06;
        check("powerup6", 32'h08000006);

        // Reset for one edge, then sweep the boot image.
        rst_n = 1'b0;
        tick();
        addr = 8'h01;
        check("rst_low", 32'h20020003);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            addr = 8'(i);
            check("boot", boot_tab[i]);
        end
        addr = 8'hFF;
        check("boot_ff", 32'h00000000);

        // Combinational read: no clock edge between these.
        addr = 8'h02;
        check("comb_a", 32'h00221820);
        addr = 8'h06;
        check("comb_b", 32'h08000006);

        // Write with read of the same word.
        we = 1'b1; wr_addr = 8'h10; wr_data = 32'hDEADBEEF; addr = 8'h10;
        check("wr_before", 32'h00000000);
        tick();
        we = 1'b0;
        check("wr_after", 32'hDEADBEEF);
        addr = 8'h11;
        check("wr_neigh", 32'h00000000);

        // Reset overrides a concurrent write.
        rst_n = 1'b0; we = 1'b1; wr_addr = 8'h00; wr_data = 32'h12345678;
        tick();
        rst_n = 1'b1; we = 1'b0; addr = 8'h00;
        check("rst_prio", 32'h20010005);
        addr = 8'h10;
        check("rst_clr10", 32'h00000000);

        // Reset mid-operation wipes a loaded program.
        we = 1'b1; wr_addr = 8'hFF; wr_data = 32'hCAFEF00D;
        tick();
        we = 1'b0; addr = 8'hFF;
        check("ld_ff", 32'hCAFEF00D);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_ff", 32'h00000000);
        addr = 8'h01;
        check("mid_rst_1", 32'h20020003);

        // Back-to-back writes to the same word.
        addr = 8'h03; we = 1'b1; wr_addr = 8'h03; wr_data = 32'h11111111;
        tick();
        check("b2b_1", 32'h11111111);
        wr_data = 32'h22222222;
        tick();
        we = 1'b0;
        check("b2b_2", 32'h22222222);

        // Randomized traffic against the model. Write and read addresses
        // are drawn from a narrow window so reads often hit written words.
        for (int n = 0; n < 300; n++) begin
            rst_n   = ($urandom_range(0, 24) != 0);
            we      = $urandom_range(0, 1) != 0;
            wr_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            wr_data = $urandom;
            addr    = ($urandom_range(0, 1) != 0) ? wr_addr : 8'($urandom_range(0, 15));
            check("rnd_pre", model[addr]);
            tick();
            check("rnd_post", model[addr]);
            addr = 8'($urandom);
            check("rnd_any", model[addr]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
